mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

- Two-port arbiter sharing one single-beat memory bus between the core's instruction fetch port and data port.
- Sits between the pipelined core and the memory system.
- Grants one requester at a time, latches its request, presents it downstream and routes the handshake responses back.
- Holds the grant until that transaction's data phase completes.

## Interface

Parameters:
- ROUND_ROBIN, default 0: 0 = data port has fixed priority; 1 = alternate on ties, starting with data.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- i_valid  in  1  instruction read request.
- i_addr  in  32  instruction address.
- i_addr_ok  out  1  address phase accepted for the instruction port.
- i_data_ok  out  1  read data valid for the instruction port.
- i_rdata  out  32  read data, driven from m_rdata unconditionally.
- d_valid  in  1  data request.
- d_addr  in  32  data address.
- d_strobe  in  4  byte write enables; 0 means read.
- d_wdata  in  32  write data.
- d_addr_ok  out  1  address phase accepted for the data port.
- d_data_ok  out  1  data phase complete for the data port.
- d_rdata  out  32  read data, driven from m_rdata unconditionally.
- m_valid  out  1  downstream request.
- m_addr  out  32  latched address.
- m_strobe  out  4  latched strobe; forced 0 for instruction grants.
- m_wdata  out  32  latched write data.
- m_addr_ok  in  1  downstream address accept.
- m_data_ok  in  1  downstream data complete.
- m_rdata  in  32  downstream read data.
- busy  out  1  state != IDLE.
- owner  out  1  current or last grant; 0 = instruction, 1 = data.

## Operation

State machine: IDLE, ADDR, DATA.

IDLE
- If either valid is set, pick a winner.
- Fixed mode: d_valid wins.
- RR mode:
  - A lone requester wins.
  - On a tie, the winner is the port other than last_owner.
- Latch addr, strobe (0 for instruction) and wdata into the request register.
- Set owner to the winner and go to ADDR.
- m_valid = 0.
- m_addr_ok and m_data_ok are ignored.

ADDR
- m_valid = 1, showing the latched fields.
- m_addr_ok is passed combinationally to the owner's x_addr_ok; the other port's x_addr_ok stays 0.
- On m_addr_ok alone: go to DATA.
- On m_addr_ok and m_data_ok in the same cycle: forward both to the owner, complete, go to IDLE.
- m_data_ok without m_addr_ok: ignored.

DATA
- m_valid = 0.
- m_data_ok is passed combinationally to the owner's x_data_ok; go to IDLE.

Completion
- last_owner <= owner.
- Only updated on completion.

General rules
- The non-owner never sees addr_ok or data_ok.
- Requester input changes after latching have no effect on the current transaction.
- A requester deasserting valid before its addr_ok is a protocol violation; the latched request is still issued and completed.
- busy = (state != IDLE).

## Timing

Reset (asynchronous, resetn low):
- state = IDLE, owner = 0, last_owner = 0.
- Request register = 0.
- m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, busy = 0.
- Reset in ADDR or DATA abandons the transaction immediately; outputs go to 0 the same instant.

Latency:
- Request seen in IDLE at cycle T: m_valid = 1 at T+1.
- Best case (addr_ok and data_ok both at T+1): x_addr_ok and x_data_ok at T+1.
- Otherwise data_ok arrives no earlier than T+2.
- Every completion is followed by one IDLE cycle, so back-to-back transactions are at least 2 cycles apart.

Other timing:
- Both ports stall independently until granted.
- There is no starvation bound in fixed mode.
- In RR mode each port waits at most one foreign transaction.

## Test plan

- Lone read: i_valid, addr 0xBFC00000; memory accepts at T+1, returns 0x3C010001 at T+2 → i_addr_ok at T+1, i_data_ok with i_rdata = 0x3C010001 at T+2, d_* oks stay 0, m_strobe = 0.
- Tie, fixed mode: i_valid and d_valid (write 0x80000010, strobe 0xF, wdata 0xDEADBEEF) at T → data granted first (m_strobe = 0xF, m_wdata = 0xDEADBEEF); instruction granted in the IDLE cycle after data completes.
- Tie, RR mode, both held valid for 4 transactions → owner sequence data, instr, data, instr; each completion followed by one busy = 0 cycle.
- Same-cycle accept and complete: m_addr_ok and m_data_ok both at T+1 → d_addr_ok and d_data_ok both at T+1, busy = 0 at T+2.
- Stall and input change: memory delays addr_ok 3 cycles while d_addr changes from 0x100 to 0x200 → m_addr stays 0x100 throughout; d_addr_ok only on the accept cycle; m_data_ok asserted in IDLE ignored.
- Async reset while in DATA: resetn low mid-cycle → m_valid, all oks and busy go to 0 immediately; after release a fresh i_valid is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port single-beat memory bus arbiter (instruction fetch vs data)
module mem_bus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction fetch port
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    // data port
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    // downstream memory bus
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    // status
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strobe_q, strobe_d;
    logic [31:0] wdata_q, wdata_d;

    logic        winner;
    logic        addr_ok;
    logic        data_ok;

    // Winner of a new grant: 1 = data port. In round-robin mode a tie goes to
    // the port that did not complete last; last_owner resets to instruction so
    // the first tie goes to data.
    always_comb begin
        winner = d_valid;
        if (ROUND_ROBIN && i_valid && d_valid) begin
            winner = ~last_owner_q;
        end
    end

    // Next-state, grant latching and completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_d  = ADDR;
                    owner_d  = winner;
                    addr_d   = winner ? d_addr : i_addr;
                    strobe_d = winner ? d_strobe : 4'h0;
                    wdata_d  = winner ? d_wdata : 32'h0;
                end
            end
            ADDR: begin
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            addr_q       <= 32'h0;
            strobe_q     <= 4'h0;
            wdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
        end
    end

    // Handshake routing: memory responses reach only the current owner, and
    // data_ok outside ADDR/DATA (or without the address accept in ADDR) is dropped.
    always_comb begin
        addr_ok   = (state_q == ADDR) && m_addr_ok;
        data_ok   = ((state_q == ADDR) && m_addr_ok && m_data_ok) ||
                    ((state_q == DATA) && m_data_ok);
        i_addr_ok = addr_ok && !owner_q;
        i_data_ok = data_ok && !owner_q;
        d_addr_ok = addr_ok && owner_q;
        d_data_ok = data_ok && owner_q;
    end

    assign m_valid = (state_q == ADDR);
    assign m_addr  = addr_q;
    assign m_strobe = strobe_q;
    assign m_wdata = wdata_q;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign busy    = (state_q != IDLE);
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (fixed and round-robin)
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [3:0]  d_strobe;
    logic [31:0] d_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    logic        fx_i_addr_ok, fx_i_data_ok, fx_d_addr_ok, fx_d_data_ok;
    logic        fx_m_valid, fx_busy, fx_owner;
    logic [31:0] fx_i_rdata, fx_d_rdata, fx_m_addr, fx_m_wdata;
    logic [3:0]  fx_m_strobe;
    logic        rr_i_addr_ok, rr_i_data_ok, rr_d_addr_ok, rr_d_data_ok;
    logic        rr_m_valid, rr_busy, rr_owner;
    logic [31:0] rr_i_rdata, rr_d_rdata, rr_m_addr, rr_m_wdata;
    logic [3:0]  rr_m_strobe;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fx (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(fx_i_addr_ok),
        .i_data_ok(fx_i_data_ok), .i_rdata(fx_i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_addr_ok(fx_d_addr_ok), .d_data_ok(fx_d_data_ok), .d_rdata(fx_d_rdata),
        .m_valid(fx_m_valid), .m_addr(fx_m_addr), .m_strobe(fx_m_strobe),
        .m_wdata(fx_m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .busy(fx_busy), .owner(fx_owner)
    );

    mem_bus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(rr_i_addr_ok),
        .i_data_ok(rr_i_data_ok), .i_rdata(rr_i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_addr_ok(rr_d_addr_ok), .d_data_ok(rr_d_data_ok), .d_rdata(rr_d_rdata),
        .m_valid(rr_m_valid), .m_addr(rr_m_addr), .m_strobe(rr_m_strobe),
        .m_wdata(rr_m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .busy(rr_busy), .owner(rr_owner)
    );

    // Flag vector: {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_valid, busy, owner}
    logic [6:0]  fx_flags, rr_flags;
    logic [6:0]  o_flags [2];
    logic [31:0] o_addr [2];
    logic [3:0]  o_strobe [2];
    logic [31:0] o_wdata [2];
    logic [31:0] o_irdata [2];
    logic [31:0] o_drdata [2];

    assign fx_flags = {fx_i_addr_ok, fx_i_data_ok, fx_d_addr_ok, fx_d_data_ok, fx_m_valid, fx_busy, fx_owner};
    assign rr_flags = {rr_i_addr_ok, rr_i_data_ok, rr_d_addr_ok, rr_d_data_ok, rr_m_valid, rr_busy, rr_owner};
    assign o_flags[0] = fx_flags;
    assign o_flags[1] = rr_flags;
    assign o_addr[0] = fx_m_addr;
    assign o_addr[1] = rr_m_addr;
    assign o_strobe[0] = fx_m_strobe;
    assign o_strobe[1] = rr_m_strobe;
    assign o_wdata[0] = fx_m_wdata;
    assign o_wdata[1] = rr_m_wdata;
    assign o_irdata[0] = fx_i_rdata;
    assign o_irdata[1] = rr_i_rdata;
    assign o_drdata[0] = fx_d_rdata;
    assign o_drdata[1] = rr_d_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the rising edge; return mid-cycle for sampling.
    task automatic cyc(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic [3:0] ds, input logic [31:0] dw,
                       input logic mao, input logic mdo, input logic [31:0] mr);
        @(posedge clk);
        #1;
        i_valid = iv; i_addr = ia;
        d_valid = dv; d_addr = da; d_strobe = ds; d_wdata = dw;
        m_addr_ok = mao; m_data_ok = mdo; m_rdata = mr;
        #3;
    endtask

    task automatic zero_inputs();
        i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_strobe = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        resetn = 0;
        @(posedge clk);
        @(posedge clk);
        #3 resetn = 1;
    endtask

    task automatic test_reset();
        zero_inputs();
        resetn = 0;
        @(posedge clk);
        #2;
        checks++;
        if (fx_flags !== 7'b0 || rr_flags !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got fx=%b rr=%b exp=0000000", fx_flags, rr_flags);
        end
        checks++;
        if (fx_m_addr !== 32'h0 || fx_m_strobe !== 4'h0 || fx_m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_req got addr=%h strobe=%h wdata=%h exp=0", fx_m_addr, fx_m_strobe, fx_m_wdata);
        end
        @(posedge clk);
        #3 resetn = 1;
    endtask

    task automatic test_lone_read();
        cyc(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fx_flags !== 7'b0000000) begin
            errors++; $display("FAIL lone_t0 got=%b exp=0000000", fx_flags);
        end
        cyc(1, 32'hBFC00000, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (fx_flags !== 7'b1000110 || rr_flags !== 7'b1000110) begin
            errors++; $display("FAIL lone_addr got fx=%b rr=%b exp=1000110", fx_flags, rr_flags);
        end
        checks++;
        if (fx_m_addr !== 32'hBFC00000 || fx_m_strobe !== 4'h0) begin
            errors++; $display("FAIL lone_fields got addr=%h strobe=%h exp=bfc00000/0", fx_m_addr, fx_m_strobe);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3C010001);
        checks++;
        if (fx_flags !== 7'b0100010 || fx_i_rdata !== 32'h3C010001) begin
            errors++; $display("FAIL lone_data got flags=%b rdata=%h exp=0100010/3c010001", fx_flags, fx_i_rdata);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fx_flags !== 7'b0000000) begin
            errors++; $display("FAIL lone_idle got=%b exp=0000000", fx_flags);
        end
    endtask

    task automatic test_tie_fixed();
        logic [6:0] e;
        cyc(1, 32'h1000, 1, 32'h80000010, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        // data wins and completes with accept and data in the same cycle
        cyc(1, 32'h1000, 1, 32'h80000010, 4'hF, 32'hDEADBEEF, 1, 1, 0);
        checks++;
        if (fx_flags !== 7'b0011111 || rr_flags !== 7'b0011111) begin
            errors++; $display("FAIL tie_data got fx=%b rr=%b exp=0011111", fx_flags, rr_flags);
        end
        checks++;
        if (fx_m_addr !== 32'h80000010 || fx_m_strobe !== 4'hF || fx_m_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL tie_fields got addr=%h strobe=%h wdata=%h exp=80000010/f/deadbeef", fx_m_addr, fx_m_strobe, fx_m_wdata);
        end
        cyc(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fx_flags !== 7'b0000001) begin
            errors++; $display("FAIL tie_gap got=%b exp=0000001", fx_flags);
        end
        cyc(1, 32'h1000, 0, 0, 0, 0, 1, 0, 0);
        e = 7'b1000110;
        checks++;
        if (fx_flags !== e || fx_m_addr !== 32'h1000 || fx_m_strobe !== 4'h0) begin
            errors++; $display("FAIL tie_instr got flags=%b addr=%h strobe=%h exp=%b/00001000/0", fx_flags, fx_m_addr, fx_m_strobe, e);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
        checks++;
        if (fx_flags !== 7'b0100010) begin
            errors++; $display("FAIL tie_instr_data got=%b exp=0100010", fx_flags);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_rr_tie();
        logic       eo;
        logic [6:0] e;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            cyc(1, 32'h400 + t, 1, 32'h800 + t, 4'h3, 32'hA5A50000 + t, 0, 0, 0);
            checks++;
            if (rr_busy !== 1'b0 || fx_busy !== 1'b0) begin
                errors++; $display("FAIL rr_gap%0d got rr=%b fx=%b exp=0", t, rr_busy, fx_busy);
            end
            cyc(1, 32'h400 + t, 1, 32'h800 + t, 4'h3, 32'hA5A50000 + t, 1, 1, 0);
            eo = (t % 2 == 0);
            e = {!eo, !eo, eo, eo, 1'b1, 1'b1, eo};
            checks++;
            if (rr_flags !== e || rr_m_addr !== (eo ? 32'h800 + t : 32'h400 + t)) begin
                errors++; $display("FAIL rr_txn%0d got flags=%b addr=%h exp=%b", t, rr_flags, rr_m_addr, e);
            end
            checks++;
            if (fx_owner !== 1'b1) begin
                errors++; $display("FAIL rr_fixed_owner%0d got=%b exp=1", t, fx_owner);
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (rr_busy !== 1'b0) begin
            errors++; $display("FAIL rr_final_gap got=%b exp=0", rr_busy);
        end
    endtask

    task automatic test_stall_change();
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (fx_flags !== 7'b0) begin
            errors++; $display("FAIL stall_idle_dok got=%b exp=0000000", fx_flags);
        end
        cyc(0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 32'h200, 0, 0, 0, (k == 0), 0);
            checks++;
            if (fx_flags !== 7'b0000111 || fx_m_addr !== 32'h100) begin
                errors++; $display("FAIL stall_wait%0d got flags=%b addr=%h exp=0000111/00000100", k, fx_flags, fx_m_addr);
            end
        end
        cyc(0, 0, 1, 32'h200, 0, 0, 1, 0, 0);
        checks++;
        if (fx_flags !== 7'b0010111 || fx_m_addr !== 32'h100) begin
            errors++; $display("FAIL stall_accept got flags=%b addr=%h exp=0010111/00000100", fx_flags, fx_m_addr);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (fx_flags !== 7'b0001011) begin
            errors++; $display("FAIL stall_data got=%b exp=0001011", fx_flags);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        cyc(1, 32'h2000, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h2000, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        checks++;
        if (fx_flags !== 7'b0100010) begin
            errors++; $display("FAIL areset_pre got=%b exp=0100010", fx_flags);
        end
        #1 resetn = 0;
        #1;
        checks++;
        if (fx_flags !== 7'b0 || rr_flags !== 7'b0 || fx_m_addr !== 32'h0) begin
            errors++; $display("FAIL areset_now got fx=%b rr=%b addr=%h exp=0", fx_flags, rr_flags, fx_m_addr);
        end
        zero_inputs();
        @(posedge clk);
        #3 resetn = 1;
        cyc(1, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fx_flags !== 7'b0000110 || fx_m_addr !== 32'h3000) begin
            errors++; $display("FAIL areset_regrant got flags=%b addr=%h exp=0000110/00003000", fx_flags, fx_m_addr);
        end
        cyc(1, 32'h3000, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Random traffic against a transaction-level model of each arbiter instance.
    task automatic test_random();
        bit          act [2];
        bit          acc [2];
        bit          own [2];
        bit          lown [2];
        logic [31:0] ta [2];
        logic [31:0] tw [2];
        logic [3:0]  ts [2];
        logic        iv, dv, mao, mdo, eaok, edok, w;
        logic [31:0] ia, da, dw, mr;
        logic [3:0]  ds;
        logic [6:0]  ef;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; acc[k] = 0; own[k] = 0; lown[k] = 0;
            ta[k] = 0; tw[k] = 0; ts[k] = 0;
        end
        for (int n = 0; n < 600; n++) begin
            iv = ($urandom_range(0, 2) != 0);
            dv = ($urandom_range(0, 2) != 0);
            ia = $urandom; da = $urandom; dw = $urandom;
            ds = 4'($urandom);
            mao = ($urandom_range(0, 2) != 0);
            mdo = ($urandom_range(0, 1) != 0);
            mr = $urandom;
            cyc(iv, ia, dv, da, ds, dw, mao, mdo, mr);
            for (int k = 0; k < 2; k++) begin
                eaok = act[k] && !acc[k] && mao;
                edok = act[k] && (acc[k] ? mdo : (mao && mdo));
                ef = {eaok && !own[k], edok && !own[k], eaok && own[k], edok && own[k],
                      act[k] && !acc[k], act[k], own[k]};
                checks++;
                if (o_flags[k] !== ef) begin
                    errors++; $display("FAIL rand_flags inst=%0d cyc=%0d got=%b exp=%b", k, n, o_flags[k], ef);
                end
                checks++;
                if (o_addr[k] !== ta[k] || o_strobe[k] !== ts[k] || (own[k] && o_wdata[k] !== tw[k])) begin
                    errors++;
                    $display("FAIL rand_fields inst=%0d cyc=%0d got=%h/%h/%h exp=%h/%h/%h", k, n,
                             o_addr[k], o_strobe[k], o_wdata[k], ta[k], ts[k], tw[k]);
                end
                checks++;
                if (o_irdata[k] !== mr || o_drdata[k] !== mr) begin
                    errors++; $display("FAIL rand_rdata inst=%0d cyc=%0d got=%h/%h exp=%h", k, n, o_irdata[k], o_drdata[k], mr);
                end
                if (act[k]) begin
                    if (edok) begin
                        act[k] = 0;
                        lown[k] = own[k];
                    end else if (eaok) begin
                        acc[k] = 1;
                    end
                end else if (iv || dv) begin
                    w = (k == 0) ? dv : ((iv && dv) ? !lown[k] : dv);
                    own[k] = w;
                    ta[k] = w ? da : ia;
                    ts[k] = w ? ds : 4'h0;
                    tw[k] = w ? dw : 32'h0;
                    act[k] = 1;
                    acc[k] = 0;
                end
            end
        end
    endtask

    initial begin
        resetn = 0;
        zero_inputs();
        test_reset();
        test_lone_read();
        test_tie_fixed();
        test_rr_tie();
        test_stall_change();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
